// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
// Frame: CNT_LO, CNT_HI, N x {WORD_LO, WORD_HI}, CHK.
package loader_pkg;

  localparam int LD_D = 12;
  localparam int LD_W = 9;

  localparam logic [7:0] CNT_HI_MASK = 8'hF0;
  localparam logic [7:0] WHI_MASK    = 8'hFE;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    WORD_LO,
    WORD_HI,
    CHK,
    DONE,
    ERR
  } ld_state_t;

endpackage

// File: rtl/imem_word_pack.sv
// Latches the low byte of a word and issues the registered
// one-cycle instruction-memory write strobe.
module imem_word_pack
  import loader_pkg::*;
#(
  parameter int D = LD_D,
  parameter int W = LD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lo_we_i,
  input  logic         hi_we_i,
  input  logic [7:0]   byte_i,
  input  logic [D-1:0] addr_i,
  output logic         wr_en_o,
  output logic [D-1:0] wr_addr_o,
  output logic [W-1:0] wr_data_o
);

  logic [7:0]   lo_q;
  logic         en_q;
  logic [D-1:0] addr_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      en_q <= hi_we_i;
      if (lo_we_i) lo_q <= byte_i;
      // address is held between strobes
      if (hi_we_i) begin
        addr_q <= addr_i;
        data_q <= W'({byte_i[0], lo_q});
      end
    end
  end

  assign wr_en_o   = en_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;

endmodule

// File: rtl/imem_loader.sv
// Host byte-stream loader for the instruction memory; holds the
// core in reset until a frame has loaded with a matching checksum.
module imem_loader
  import loader_pkg::*;
#(
  parameter int D = LD_D,
  parameter int W = LD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic         restart,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         load_err
);

  localparam logic [12:0] NMAX = 13'(1 << D);

  ld_state_t    state_q, state_d;
  logic [11:0]  rem_q, rem_d;
  logic [D-1:0] idx_q, idx_d;
  logic [7:0]   chk_q, chk_d;
  logic         acc, lo_we, hi_we;
  logic [11:0]  n_w;

  assign acc = in_valid & in_ready;
  // CNT_LO sits in rem_q while CNT_HI is being received
  assign n_w = {in_data[3:0], rem_q[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HDR_LO;
      rem_q   <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    lo_we   = 1'b0;
    hi_we   = 1'b0;
    if (acc && state_q != CHK) chk_d = chk_q ^ in_data;
    unique case (state_q)
      HDR_LO: if (acc) begin
        rem_d   = {4'h0, in_data};
        state_d = HDR_HI;
      end
      HDR_HI: if (acc) begin
        rem_d = n_w;
        if ((in_data & CNT_HI_MASK) != 8'h00 ||
            {1'b0, n_w} > NMAX) state_d = ERR;
        else if (n_w == 12'd0) state_d = CHK;
        else state_d = WORD_LO;
      end
      WORD_LO: if (acc) begin
        lo_we   = 1'b1;
        state_d = WORD_HI;
      end
      WORD_HI: if (acc) begin
        if ((in_data & WHI_MASK) != 8'h00) begin
          state_d = ERR;
        end else begin
          hi_we   = 1'b1;
          idx_d   = idx_q + {{(D-1){1'b0}}, 1'b1};
          rem_d   = rem_q - 12'd1;
          state_d = (rem_q == 12'd1) ? CHK : WORD_LO;
        end
      end
      CHK: if (acc) begin
        state_d = (in_data == chk_q) ? DONE : ERR;
      end
      DONE, ERR: if (restart) begin
        state_d = HDR_LO;
        rem_d   = '0;
        idx_d   = '0;
        chk_d   = '0;
      end
      default: state_d = HDR_LO;
    endcase
  end

  assign in_ready  = (state_q != DONE) && (state_q != ERR);
  assign cpu_hold  = (state_q != DONE);
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERR);

  imem_word_pack #(
    .D(D),
    .W(W)
  ) u_pack (
    .clk      (clk),
    .rst_n    (reset),
    .lo_we_i  (lo_we),
    .hi_we_i  (hi_we),
    .byte_i   (in_data),
    .addr_i   (idx_q),
    .wr_en_o  (wr_en),
    .wr_addr_o(wr_addr),
    .wr_data_o(wr_data)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are parsed by a
// reference model, expected writes queued, a monitor checks them.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [8:0]  wr_data;
  logic        cpu_hold, load_done, load_err;

  imem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .restart  (restart),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int bidx;
  } wr_t;

  wr_t        expq[$];
  wr_t        e;
  logic [7:0] frm[$];
  time        acc_t[0:1023];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write,
  // one cycle after its WORD_HI byte was accepted.
  always @(negedge clk) begin
    if (reset === 1'b1 && wr_en === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h", wr_addr, wr_data);
      end else begin
        e = expq.pop_front();
        if (int'(wr_addr) != e.addr || int'(wr_data) != e.data ||
            $time != acc_t[e.bidx] + 5) begin
          failures++;
          $display("FAIL write got=(%0h,%0h @%0t) exp=(%0h,%0h @%0t)",
                   wr_addr, wr_data, $time, e.addr, e.data,
                   acc_t[e.bidx] + 5);
        end
      end
    end
  end

  // Reference parse of frm: queues the writes, returns how many bytes
  // the loader consumes and the final status (0 open, 1 done, 2 err).
  task automatic model_frame(output int nacc, output int st);
    int n, p;
    logic [7:0] x, hi, lo;
    st = 0;
    nacc = frm.size();
    if (frm.size() < 2) return;
    x = frm[0] ^ frm[1];
    hi = frm[1];
    if (hi[7:4] != 4'h0) begin
      nacc = 2; st = 2; return;
    end
    n = int'({hi[3:0], frm[0]});
    for (int i = 0; i < n; i++) begin
      p = 2 + 2 * i;
      if (p + 1 >= frm.size()) return;
      lo = frm[p];
      hi = frm[p + 1];
      if (hi[7:1] != 7'h00) begin
        nacc = p + 2; st = 2; return;
      end
      expq.push_back('{addr: i % 4096, data: int'({hi[0], lo}), bidx: p + 1});
      x = x ^ lo ^ hi;
    end
    p = 2 + 2 * n;
    if (p >= frm.size()) return;
    nacc = p + 1;
    st = (frm[p] == x) ? 1 : 2;
  endtask

  task automatic append_chk(input bit bad);
    logic [7:0] x = 8'h00;
    foreach (frm[i]) x ^= frm[i];
    frm.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  // mode: 0 good, 1 bad checksum, 2 bad WORD_HI, 3 bad CNT_HI
  task automatic mk_rand(input int n, input int mode);
    logic [11:0] nn = 12'(n);
    int bad = (n > 0) ? $urandom_range(0, n - 1) : 0;
    frm.delete();
    frm.push_back(nn[7:0]);
    frm.push_back({(mode == 3) ? 4'h2 : 4'h0, nn[11:8]});
    for (int i = 0; i < n; i++) begin
      frm.push_back(8'($urandom));
      if (mode == 2 && i == bad) frm.push_back(8'h80 | 8'($urandom_range(0, 1)));
      else frm.push_back(8'($urandom_range(0, 1)));
    end
    append_chk(mode == 1);
  endtask

  task automatic send(input int nb, input int gaps);
    for (int k = 0; k < nb; k++) begin
      if (gaps != 0) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frm[k];
      if (in_ready !== 1'b1) chk("in_ready_rx", int'(in_ready), 1);
      @(posedge clk);
      acc_t[k] = $time;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_end(input int st);
    repeat (2) @(negedge clk);
    chk("load_done", int'(load_done), int'(st == 1));
    chk("load_err", int'(load_err), int'(st == 2));
    chk("cpu_hold", int'(cpu_hold), int'(st != 1));
    chk("in_ready_end", int'(in_ready), int'(st == 0));
    chk("writes_left", expq.size(), 0);
  endtask

  // Bytes offered in DONE/ERR are ignored; restart wins over a byte.
  task automatic idle_and_restart(input int st);
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("ignored_done", int'(load_done), int'(st == 1));
    chk("ignored_err", int'(load_err), int'(st == 2));
    restart = 1'b1;
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_hold", int'(cpu_hold), 1);
    chk("rst_flags", int'({load_done, load_err}), 0);
  endtask

  task automatic run_frame(input int gaps);
    int nacc, st;
    model_frame(nacc, st);
    send(nacc, gaps);
    check_end(st);
    idle_and_restart(st);
  endtask

  task automatic check_reset_outs(string tag);
    chk({tag, "_ready"}, int'(in_ready), 1);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_hold"}, int'(cpu_hold), 1);
    chk({tag, "_done"}, int'(load_done), 0);
    chk({tag, "_err"}, int'(load_err), 0);
  endtask

  initial begin
    #12;
    check_reset_outs("por");
    @(negedge clk);
    reset = 1'b1;

    frm = '{8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h00};
    append_chk(1'b0);
    run_frame(0);

    frm = '{8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h00};
    append_chk(1'b1);
    run_frame(0);

    frm = '{8'h00, 8'h00, 8'h00};
    run_frame(0);
    frm = '{8'h00, 8'h00, 8'h01};
    run_frame(0);

    frm = '{8'h01, 8'h00, 8'h55, 8'h02, 8'h00};
    run_frame(0);
    frm = '{8'h00, 8'h10};
    run_frame(0);

    mk_rand(64, 0);
    run_frame(1);
    mk_rand(64, 0);
    run_frame(0);

    for (int r = 0; r < 12; r++) begin
      mk_rand($urandom_range(0, 9), $urandom_range(0, 3));
      run_frame($urandom_range(0, 1));
    end

    // Abort an N=4 load right after word 1 is written.
    mk_rand(4, 0);
    begin
      int nacc, st;
      model_frame(nacc, st);
      send(6, 0);
    end
    #1 reset = 1'b0;
    #1 check_reset_outs("arst");
    expq.delete();
    @(negedge clk);
    reset = 1'b1;
    mk_rand(4, 0);
    run_frame(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
